// File: rtl/gbt_rx_frameclk_phalgnr_pkg.sv
// Shared types and constants for the RX frame-clock phase aligner DPS logic.
package gbt_rx_frameclk_phalgnr_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EN_HI     = 2'd1,
    WAIT_DONE = 2'd2,
    FIN       = 2'd3
  } dps_state_t;

  localparam logic [4:0] CNTSEL_C0 = 5'b00000;

  // 720 MHz VCO, 8 phases, 18 VCO periods per 40 MHz frame-clock period
  localparam int DEF_STEPS_PER_PERIOD = 144;
  localparam int DEF_TIMEOUT_CYC      = 1023;

endpackage

// File: rtl/gbt_rx_frameclk_phalgnr_dps_pos.sv
// Modulo up/down counter tracking the DPS phase offset in VCO steps.
module gbt_rx_frameclk_phalgnr_dps_pos
  import gbt_rx_frameclk_phalgnr_pkg::*;
#(
  parameter int MODULUS = DEF_STEPS_PER_PERIOD,
  parameter int POS_W   = 8
) (
  input  logic             scanclk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic             up,
  output logic [POS_W-1:0] position
);

  localparam logic [POS_W-1:0] POS_TOP = POS_W'(MODULUS - 1);

  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) begin
      position <= '0;
    end else if (clr) begin
      position <= '0;
    end else if (step) begin
      if (up) begin
        position <= (position == POS_TOP) ? '0 : position + 1'b1;
      end else begin
        position <= (position == '0) ? POS_TOP : position - 1'b1;
      end
    end
  end

endmodule

// File: rtl/gbt_rx_frameclk_phalgnr_dps_ctrl.sv
// Cyclone V PLL dynamic-phase-shift initiator: one phase_en/phase_done handshake per step.
// Optional position output enabled by GBT_RX_FRAMECLK_PHALGNR_DPS_POSITION_EN.
module gbt_rx_frameclk_phalgnr_dps_ctrl
  import gbt_rx_frameclk_phalgnr_pkg::*;
#(
  parameter int STEP_W      = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`ifdef GBT_RX_FRAMECLK_PHALGNR_DPS_POSITION_EN
  ,
  parameter int STEPS_PER_PERIOD = DEF_STEPS_PER_PERIOD,
  parameter int POS_W            = 8
`endif
) (
  input  logic              scanclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_updn,
  input  logic [STEP_W-1:0] req_steps,
  input  logic [4:0]        req_cntsel,
  output logic              phase_en,
  output logic              updn,
  output logic [4:0]        cntsel,
  input  logic              phase_done,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_unlock
`ifdef GBT_RX_FRAMECLK_PHALGNR_DPS_POSITION_EN
  ,
  output logic [POS_W-1:0]  position
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

  dps_state_t        state;
  dps_state_t        state_nxt;
  logic [STEP_W-1:0] remaining;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              accept;
  logic              active;
  logic              progress;
  logic              timeout;

  assign req_ready = (state == IDLE) && pll_locked;
  assign accept    = req_valid && req_ready;
  assign active    = (state == EN_HI) || (state == WAIT_DONE);

  // A handshake edge seen in the same cycle as the timeout still counts as progress
  assign progress  = ((state == EN_HI) && !phase_done) ||
                     ((state == WAIT_DONE) && phase_done);
  assign timeout   = active && (tmo_cnt == TMO_MAX) && !progress;

  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (accept) begin
        state_nxt = (req_steps == '0) ? FIN : EN_HI;
      end
    end else if (!pll_locked || timeout) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        EN_HI: begin
          if (!phase_done) state_nxt = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (phase_done) state_nxt = (remaining == STEP_W'(1)) ? FIN : EN_HI;
        end
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Pulses are gated by lock so an unlock abort never shows done/timeout alongside it
  always_comb begin
    phase_en    = 1'b0;
    busy        = (state != IDLE);
    done        = 1'b0;
    err_timeout = 1'b0;
    err_unlock  = 1'b0;
    if (state != IDLE) begin
      if (!pll_locked) begin
        err_unlock = 1'b1;
      end else if (timeout) begin
        err_timeout = 1'b1;
      end else begin
        phase_en = (state == EN_HI);
        done     = (state == FIN);
      end
    end
  end

  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if ((state_nxt != state) || !active) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      updn      <= 1'b0;
      cntsel    <= CNTSEL_C0;
    end else if (accept) begin
      remaining <= req_steps;
      updn      <= req_updn;
      cntsel    <= req_cntsel;
    end else if ((state == WAIT_DONE) && phase_done && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
    end
  end

`ifdef GBT_RX_FRAMECLK_PHALGNR_DPS_POSITION_EN
  logic step_done;

  assign step_done = (state == WAIT_DONE) && phase_done && pll_locked;

  gbt_rx_frameclk_phalgnr_dps_pos #(
    .MODULUS (STEPS_PER_PERIOD),
    .POS_W   (POS_W)
  ) u_pos (
    .scanclk  (scanclk),
    .rst_n    (rst_n),
    .clr      (!pll_locked),
    .step     (step_done),
    .up       (updn),
    .position (position)
  );
`endif

endmodule
